// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: shifts x into an N-bit history and
// pulses F for one cycle when the last N sampled bits equal PATTERN.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      EN,
  input  logic                      x,
  input  logic                      CLR,
  output logic                      F,
  output logic [N-1:0]              S,
  output logic [$clog2(N+1)-1:0]    FILL,
  output logic [CNT_W-1:0]          COUNT
);

  localparam int FW = $clog2(N+1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N-1:0]  s_nx;
  logic [FW-1:0] fill_nx;
  logic          match;

  // Match is judged on the values the history will hold after this sample,
  // and only once N real bits have been taken so a cleared history never matches.
  always_comb begin
    s_nx    = {S[N-2:0], x};
    fill_nx = FILL;
    if (FILL != FILL_MAX)
      fill_nx = FILL + FW'(1);
    match = (s_nx == PATTERN) && (fill_nx == FILL_MAX);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      F     <= 1'b0;
      S     <= '0;
      FILL  <= '0;
      COUNT <= '0;
    end else if (CLR) begin
      F     <= 1'b0;
      S     <= '0;
      FILL  <= '0;
      COUNT <= '0;
    end else if (EN) begin
      F <= match;
      S <= s_nx;
      if (match) begin
        if (COUNT != CNT_MAX)
          COUNT <= COUNT + CNT_W'(1);
        // Non-overlapping mode forces the next match to use N fresh bits.
        if (OVERLAP)
          FILL <= fill_nx;
        else
          FILL <= '0;
      end else begin
        FILL <= fill_nx;
      end
    end else begin
      F <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: four parameterisations share the
// stimulus bus; each queued expectation names which instance it checks.
module tb_seq_detect_param;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic EN = 1'b0;
  logic x = 1'b0;
  logic CLR = 1'b0;

  logic       f_a, f_b, f_c, f_d;
  logic [3:0] s_a, s_b, s_c, s_d;
  logic [2:0] fill_a, fill_b, fill_c, fill_d;
  logic [7:0] count_a, count_b, count_d;
  logic [1:0] count_c;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         sel;
    int         test;
    int         step;
    logic       f;
    logic [3:0] s;
    logic [2:0] fill;
    logic [7:0] count;
  } exp_t;

  exp_t sb_q[$];
  int   cur_sel = 0;
  int   cur_test = 0;
  int   cur_step = 0;

  always #5 CLK = ~CLK;

  seq_detect_param dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR),
    .F(f_a), .S(s_a), .FILL(fill_a), .COUNT(count_a)
  );

  seq_detect_param #(.OVERLAP(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR),
    .F(f_b), .S(s_b), .FILL(fill_b), .COUNT(count_b)
  );

  seq_detect_param #(.PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR),
    .F(f_c), .S(s_c), .FILL(fill_c), .COUNT(count_c)
  );

  seq_detect_param #(.PATTERN(4'b0000)) dut_d (
    .CLK(CLK), .RESET(RESET), .EN(EN), .x(x), .CLR(CLR),
    .F(f_d), .S(s_d), .FILL(fill_d), .COUNT(count_d)
  );

  task automatic push_exp(input logic ef, input logic [3:0] es,
                          input logic [2:0] efill, input logic [7:0] ecount);
    exp_t e;
    e.sel   = cur_sel;
    e.test  = cur_test;
    e.step  = cur_step;
    e.f     = ef;
    e.s     = es;
    e.fill  = efill;
    e.count = ecount;
    sb_q.push_back(e);
    cur_step++;
  endtask

  // Drive one cycle of inputs; the expectation is for the state after the next edge.
  task automatic apply_stimulus(input logic en_v, input logic x_v, input logic clr_v,
                                input logic ef, input logic [3:0] es,
                                input logic [2:0] efill, input logic [7:0] ecount);
    @(negedge CLK);
    EN  = en_v;
    x   = x_v;
    CLR = clr_v;
    push_exp(ef, es, efill, ecount);
  endtask

  // Reset is raised mid-cycle, so the monitor samples it with no clock edge in between.
  task automatic pulse_reset(input int sel, input int test);
    @(negedge CLK);
    EN       = 1'b0;
    CLR      = 1'b0;
    cur_sel  = sel;
    cur_test = test;
    cur_step = 0;
    push_exp(1'b0, 4'b0000, 3'd0, 8'd0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic check_output(input exp_t e);
    logic       af;
    logic [3:0] as;
    logic [2:0] afill;
    logic [7:0] acount;
    case (e.sel)
      0:       begin af = f_a; as = s_a; afill = fill_a; acount = count_a; end
      1:       begin af = f_b; as = s_b; afill = fill_b; acount = count_b; end
      2:       begin af = f_c; as = s_c; afill = fill_c; acount = {6'd0, count_c}; end
      default: begin af = f_d; as = s_d; afill = fill_d; acount = count_d; end
    endcase
    checks++;
    if (af !== e.f || as !== e.s || afill !== e.fill || acount !== e.count) begin
      errors++;
      $display("[TB] FAIL t%0d step%0d dut%0d: got F=%b S=%b FILL=%0d COUNT=%0d, want F=%b S=%b FILL=%0d COUNT=%0d",
               e.test, e.step, e.sel, af, as, afill, acount, e.f, e.s, e.fill, e.count);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or posedge RESET);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Test 1: overlapping 1011 detection
    pulse_reset(0, 1);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0101, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd1);
    apply_stimulus(1, 0, 0, 0, 4'b0110, 3'd4, 8'd1);
    apply_stimulus(1, 1, 0, 0, 4'b1101, 3'd4, 8'd1);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd2);
    apply_stimulus(0, 0, 0, 0, 4'b1011, 3'd4, 8'd2);

    // Test 2: non-overlapping, same stream
    pulse_reset(1, 2);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0101, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd0, 8'd1);
    apply_stimulus(1, 0, 0, 0, 4'b0110, 3'd1, 8'd1);
    apply_stimulus(1, 1, 0, 0, 4'b1101, 3'd2, 8'd1);
    apply_stimulus(1, 1, 0, 0, 4'b1011, 3'd3, 8'd1);

    // Test 3: enable gap holds history and suppresses F
    pulse_reset(0, 3);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(0, 1, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(0, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(0, 1, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0101, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd1);
    apply_stimulus(0, 1, 0, 0, 4'b1011, 3'd4, 8'd1);

    // Test 4: 1111 with a 2-bit saturating counter
    pulse_reset(2, 4);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0011, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0111, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1111, 3'd4, 8'd1);
    apply_stimulus(1, 1, 0, 1, 4'b1111, 3'd4, 8'd2);
    apply_stimulus(1, 1, 0, 1, 4'b1111, 3'd4, 8'd3);
    apply_stimulus(1, 1, 0, 1, 4'b1111, 3'd4, 8'd3);
    apply_stimulus(1, 1, 0, 1, 4'b1111, 3'd4, 8'd3);

    // Test 5: all-zero pattern needs a full fill; CLR beats a completing bit
    pulse_reset(3, 5);
    apply_stimulus(1, 0, 0, 0, 4'b0000, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0000, 3'd2, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0000, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 1, 4'b0000, 3'd4, 8'd1);
    apply_stimulus(1, 0, 1, 0, 4'b0000, 3'd0, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0000, 3'd1, 8'd0);

    // Test 6: three matches, then async reset between edges
    pulse_reset(0, 6);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0101, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd1);
    apply_stimulus(1, 0, 0, 0, 4'b0110, 3'd4, 8'd1);
    apply_stimulus(1, 1, 0, 0, 4'b1101, 3'd4, 8'd1);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd2);
    apply_stimulus(1, 0, 0, 0, 4'b0110, 3'd4, 8'd2);
    apply_stimulus(1, 1, 0, 0, 4'b1101, 3'd4, 8'd2);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd3);
    pulse_reset(0, 6);
    apply_stimulus(1, 1, 0, 0, 4'b0001, 3'd1, 8'd0);
    apply_stimulus(1, 0, 0, 0, 4'b0010, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 0, 4'b0101, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 1, 4'b1011, 3'd4, 8'd1);

    @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
